// File: rtl/la_capture_wb.sv
// Logic-analyzer capture engine on a Wishbone slave port. It samples probe_i into a ring buffer,
// fires on a masked-value match, then records a programmed number of post-trigger samples.
module la_capture_wb #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] probe_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  output logic        capture_done_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  // state | meaning
  // IDLE     | no capture running
  // PRETRIG  | sampling into ring buffer, waiting for trigger match
  // POSTTRIG | sampling the programmed number of post-trigger words
  // DONE     | buffer frozen, capture_done_o high
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRETRIG  = 2'd1,
    ST_POSTTRIG = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] trigpos_q, remaining_q, postcount_q;
  logic [31:0]           trig_mask_q, trig_value_q;
  logic                  ack_q, err_q, rd_mem_q;
  logic [31:0]           reg_rd_q, mem_rd_q, reg_rdata;
  logic [31:0]           mem [DEPTH];

  logic                  req, is_mem, reg_ok, acc_ok, reg_wr, ctrl_wr, arm, abort;
  logic                  mem_we, trig_hit;
  logic [12:0]           reg_idx;
  logic [DEPTH_LOG2-1:0] mem_raddr;
  logic                  unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:16], wbs_adr_i[1:0]};

  assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q & ~err_q;
  assign is_mem    = wbs_adr_i[15];
  assign reg_idx   = wbs_adr_i[14:2];
  assign mem_raddr = wbs_adr_i[DEPTH_LOG2+1:2];

  always_comb begin
    reg_ok = 1'b0;
    case (reg_idx)
      13'd0, 13'd2, 13'd3, 13'd4: reg_ok = 1'b1;
      13'd1, 13'd5:               reg_ok = ~wbs_we_i;
      default:                    reg_ok = 1'b0;
    endcase
  end

  // Memory window is read-only; register writes need all four byte lanes.
  assign acc_ok  = is_mem ? ~wbs_we_i : (reg_ok & (~wbs_we_i | (wbs_sel_i == 4'hF)));
  assign reg_wr  = req & acc_ok & wbs_we_i;
  assign ctrl_wr = reg_wr & (reg_idx == 13'd0);
  assign abort   = ctrl_wr & wbs_dat_i[1];
  assign arm     = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1];

  assign trig_hit = ((probe_i ^ trig_value_q) & trig_mask_q) == 32'd0;

  always_comb begin
    reg_rdata = 32'd0;
    case (reg_idx)
      13'd1:   reg_rdata = {16'(trigpos_q), 14'd0, state_q};
      13'd2:   reg_rdata = trig_mask_q;
      13'd3:   reg_rdata = trig_value_q;
      13'd4:   reg_rdata = 32'(postcount_q);
      13'd5:   reg_rdata = 32'(wr_ptr_q);
      default: reg_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_mem_q <= 1'b0;
      reg_rd_q <= 32'd0;
    end else begin
      ack_q    <= req & acc_ok;
      err_q    <= req & ~acc_ok;
      rd_mem_q <= is_mem;
      reg_rd_q <= reg_rdata;
    end
  end

  // Read and write in one block give read-before-write on an address collision.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem[wr_ptr_q] <= probe_i;
    mem_rd_q <= mem[mem_raddr];
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_rty_o = 1'b0;
  assign wbs_dat_o = ~ack_q ? 32'd0 : (rd_mem_q ? mem_rd_q : reg_rd_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d = ST_PRETRIG;
    end else begin
      case (state_q)
        ST_PRETRIG:  if (trig_hit) state_d = (postcount_q == '0) ? ST_DONE : ST_POSTTRIG;
        ST_POSTTRIG: if (remaining_q == DEPTH_LOG2'(1)) state_d = ST_DONE;
        default:     state_d = state_q;
      endcase
    end
  end

  always_comb begin
    capture_done_o = (state_q == ST_DONE);
    mem_we         = ((state_q == ST_PRETRIG) | (state_q == ST_POSTTRIG)) & ~arm & ~abort;
    wr_ptr_d       = wr_ptr_q;
    if (arm)         wr_ptr_d = '0;
    else if (mem_we) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      trigpos_q    <= '0;
      remaining_q  <= '0;
      postcount_q  <= '0;
      trig_mask_q  <= 32'd0;
      trig_value_q <= 32'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      if (mem_we && state_q == ST_PRETRIG && trig_hit) begin
        trigpos_q   <= wr_ptr_q;
        remaining_q <= postcount_q;
      end else if (mem_we && state_q == ST_POSTTRIG) begin
        remaining_q <= remaining_q - DEPTH_LOG2'(1);
      end
      if (reg_wr && reg_idx == 13'd2) trig_mask_q  <= wbs_dat_i;
      if (reg_wr && reg_idx == 13'd3) trig_value_q <= wbs_dat_i;
      if (reg_wr && reg_idx == 13'd4) postcount_q  <= wbs_dat_i[DEPTH_LOG2-1:0];
    end
  end
endmodule
